// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Single-issue instruction fetch stage. Presents the PC to a
//             combinational instruction memory, captures the returned word
//             one cycle later, and handles stall, redirect (squash bubble),
//             illegal-address faults and a saturating delivery counter.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   rising-edge clock
//    rst_n        in   1   asynchronous active-low reset
//    imem_addr    out  32  byte address to instruction memory (= PC register)
//    imem_data    in   32  instruction word for imem_addr, same cycle
//    stall        in   1   consumer not ready; hold PC and outputs
//    redirect     in   1   load redirect_pc into PC (wins over stall)
//    redirect_pc  in   32  redirect byte target
//    instr        out  32  captured instruction word
//    pc_out       out  32  address instr was fetched from
//    instr_valid  out  1   instr/pc_out valid and not squashed
//    fault        out  1   sticky fetch-address error
//    fetch_count  out  16  delivered instructions, saturating
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 52
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        fault,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        seq_oob;
  logic        redir_bad;

  // Modulo-2^32 increment; running off the end is caught by seq_oob below.
  assign pc_plus4  = pc + 32'd4;
  assign seq_oob   = (pc_plus4[31:2] >= WORD_LIMIT);
  assign redir_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc[31:2] >= WORD_LIMIT);

  // Memory address comes straight from the PC register: no input-to-output path.
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      pc_out      <= 32'h0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          // One settling cycle after reset; redirect is ignored here.
          instr_valid <= 1'b0;
          state       <= RUN;
        end

        RUN: begin
          if (redirect) begin
            // Squash bubble: new PC, no capture, instr/pc_out/count hold.
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
            if (redir_bad) begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end else if (!stall) begin
            instr       <= imem_data;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            pc          <= pc_plus4;
            if (fetch_count != 16'hFFFF) begin
              fetch_count <= fetch_count + 16'd1;
            end
            // The current word is still delivered; the one after it is not.
            if (seq_oob) begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end
        end

        FAULT: begin
          // Terminal until reset: everything frozen, nothing valid.
          instr_valid <= 1'b0;
          fault       <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
